clock_divider_bank: RTL and testbench

- Multi-channel, runtime-programmable clock divider that derives several slow clocks and clock-enable ticks from the on-chip board clock.
- Each channel has a glitch-free shadowed divide register, a per-channel enable and a global phase-align strobe.
- Sits between the board clock and the modulator, decimator and UART timing logic, replacing fixed single-ratio dividers.

---
 rtl/clock_divider_bank_if.sv | 40 ++++
 rtl/clock_divider_bank.sv | 151 +++++++++++++++
 tb/tb_clock_divider_bank.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/clock_divider_bank_if.sv
// clock_divider_bank_if: control/status bundle for the clock divider bank.
// The master side drives enables, the align strobe and divide writes. The
// slave side returns the divided clocks, ticks and the write error pulse.
// Optional macro CLKDIV_PENDING_EN adds the per-channel o_pending status.
interface clock_divider_bank_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] i_ch_en;
    logic              i_sync_all;
    logic              i_wr_en;
    logic [CH_W-1:0]   i_wr_ch;
    logic [CNT_W-1:0]  i_wr_div;
    logic              o_wr_err;
    logic [NUM_CH-1:0] o_slow_clk;
    logic [NUM_CH-1:0] o_tick;
`ifdef CLKDIV_PENDING_EN
    logic [NUM_CH-1:0] o_pending;

    modport master (
        output i_ch_en, i_sync_all, i_wr_en, i_wr_ch, i_wr_div,
        input  o_wr_err, o_slow_clk, o_tick, o_pending
    );
    modport slave (
        input  i_ch_en, i_sync_all, i_wr_en, i_wr_ch, i_wr_div,
        output o_wr_err, o_slow_clk, o_tick, o_pending
    );
`else
    modport master (
        output i_ch_en, i_sync_all, i_wr_en, i_wr_ch, i_wr_div,
        input  o_wr_err, o_slow_clk, o_tick
    );
    modport slave (
        input  i_ch_en, i_sync_all, i_wr_en, i_wr_ch, i_wr_div,
        output o_wr_err, o_slow_clk, o_tick
    );
`endif
endinterface

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: NUM_CH runtime-programmable clock dividers.
// Each channel counts 0..div_active, toggling slow_clk and pulsing tick at
// the terminal count. Divide writes go to a shadow register and are copied
// into the active register only at TC, while disabled, or on sync_all, so a
// running half-period is never cut short or stretched.
// Optional macro CLKDIV_PENDING_EN adds per-channel pending status.

// One divider channel.
module clock_divider_ch #(
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 50
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr_hit,
    input  logic [CNT_W-1:0] i_wr_div,
`ifdef CLKDIV_PENDING_EN
    output logic             o_pending,
`endif
    output logic             o_slow_clk,
    output logic             o_tick
);
    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_div_active;
    logic [CNT_W-1:0] r_div_shadow;
    logic             r_slow_clk;
    logic             r_tick;
    logic [CNT_W-1:0] w_shadow_nxt;
    logic             w_tc;
    logic             w_reload;

    // A write on the same edge as a reload is bypassed straight into
    // div_active, so the reload source is the post-write shadow value.
    assign w_shadow_nxt = i_wr_hit ? i_wr_div : r_div_shadow;
    assign w_tc         = (r_count == r_div_active);
    assign w_reload     = i_sync | ~i_en | w_tc;

    // Counter, divide registers and outputs; priority sync > disable > TC.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count      <= '0;
            r_div_active <= DEF;
            r_div_shadow <= DEF;
            r_slow_clk   <= 1'b0;
            r_tick       <= 1'b0;
        end else begin
            r_div_shadow <= w_shadow_nxt;
            if (i_sync || !i_en) begin
                r_count      <= '0;
                r_slow_clk   <= 1'b0;
                r_tick       <= 1'b0;
                r_div_active <= w_shadow_nxt;
            end else if (w_tc) begin
                r_count      <= '0;
                r_slow_clk   <= ~r_slow_clk;
                r_tick       <= 1'b1;
                r_div_active <= w_shadow_nxt;
            end else begin
                // count < div_active here, so the increment cannot wrap
                r_count <= r_count + 1'b1;
                r_tick  <= 1'b0;
            end
        end
    end

`ifdef CLKDIV_PENDING_EN
    logic r_pending;

    // Pending: set by a write, cleared on the edge that copies it to active.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_pending <= 1'b0;
        else if (w_reload)
            r_pending <= 1'b0;
        else if (i_wr_hit)
            r_pending <= 1'b1;
    end

    assign o_pending = r_pending;
`endif

    assign o_slow_clk = r_slow_clk;
    assign o_tick     = r_tick;
endmodule

// Bank top: write decode, error pulse and the channel array.
module clock_divider_bank #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 50
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    clock_divider_bank_if.slave  bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] w_wr_hit;
    logic [NUM_CH-1:0] w_slow_clk;
    logic [NUM_CH-1:0] w_tick;
    logic              w_wr_bad;
    logic              r_wr_err;

    // Writes beyond the last channel touch no state, only flag an error.
    assign w_wr_bad = bus.i_wr_en && (int'(bus.i_wr_ch) >= NUM_CH);

    // One-cycle error pulse for a write to a non-existent channel.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_wr_err <= 1'b0;
        else
            r_wr_err <= w_wr_bad;
    end

`ifdef CLKDIV_PENDING_EN
    logic [NUM_CH-1:0] w_pending;
    assign bus.o_pending = w_pending;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_wr_hit[gi] = bus.i_wr_en && (bus.i_wr_ch == CH_W'(gi));

            clock_divider_ch #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .i_clk      (i_clk),
                .i_rst      (i_rst),
                .i_en       (bus.i_ch_en[gi]),
                .i_sync     (bus.i_sync_all),
                .i_wr_hit   (w_wr_hit[gi]),
                .i_wr_div   (bus.i_wr_div),
`ifdef CLKDIV_PENDING_EN
                .o_pending  (w_pending[gi]),
`endif
                .o_slow_clk (w_slow_clk[gi]),
                .o_tick     (w_tick[gi])
            );
        end
    endgenerate

    assign bus.o_wr_err   = r_wr_err;
    assign bus.o_slow_clk = w_slow_clk;
    assign bus.o_tick     = w_tick;
endmodule

// File: tb/tb_clock_divider_bank.sv
// Bench for clock_divider_bank: NUM_CH=3, CNT_W=8, DEFAULT_DIV=3.
// Hand-derived vector table, a mid-run reset sequence, then random
// stimulus checked against a half-period-length model.
module tb_clock_divider_bank;
    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int DEF = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    clock_divider_bank_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    clock_divider_bank #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .DEFAULT_DIV (DEF)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Reference model: each channel tracks the length of its current
    // half-period and how many enabled edges of it have elapsed.
    int unsigned m_shadow [NCH];
    int          m_len    [NCH];
    int          m_el     [NCH];
    bit          m_slow   [NCH];
    bit          m_tick   [NCH];
    bit          m_pend   [NCH];
    bit          m_err;

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            bit          hit;
            bit          reload;
            int unsigned nsh;
            hit    = bus.i_wr_en && (int'(bus.i_wr_ch) == c);
            nsh    = hit ? int'(bus.i_wr_div) : m_shadow[c];
            reload = 1'b0;
            if (rst) begin
                m_shadow[c] = DEF;
                m_len[c]    = DEF + 1;
                m_el[c]     = 0;
                m_slow[c]   = 1'b0;
                m_tick[c]   = 1'b0;
                m_pend[c]   = 1'b0;
            end else begin
                if (bus.i_sync_all || !bus.i_ch_en[c]) begin
                    m_el[c]   = 0;
                    m_slow[c] = 1'b0;
                    m_tick[c] = 1'b0;
                    m_len[c]  = nsh + 1;
                    reload    = 1'b1;
                end else begin
                    m_el[c] = m_el[c] + 1;
                    if (m_el[c] == m_len[c]) begin
                        m_slow[c] = ~m_slow[c];
                        m_tick[c] = 1'b1;
                        m_el[c]   = 0;
                        m_len[c]  = nsh + 1;
                        reload    = 1'b1;
                    end else begin
                        m_tick[c] = 1'b0;
                    end
                end
                if (reload)   m_pend[c] = 1'b0;
                else if (hit) m_pend[c] = 1'b1;
                m_shadow[c] = nsh;
            end
        end
        m_err = !rst && bus.i_wr_en && (int'(bus.i_wr_ch) >= NCH);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s #%0d: got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] en, input logic sy, input logic wr,
                         input logic [1:0] ch, input logic [7:0] dv);
        bus.i_ch_en    = en;
        bus.i_sync_all = sy;
        bus.i_wr_en    = wr;
        bus.i_wr_ch    = ch;
        bus.i_wr_div   = dv;
    endtask

    typedef struct {
        logic [2:0] en;
        logic       sy;
        logic       wr;
        logic [1:0] ch;
        logic [7:0] dv;
        logic [2:0] tick;
        logic [2:0] slow;
        logic       err;
        logic [2:0] pend;
    } vec_t;

    vec_t tbl [19];

    initial begin
        logic [2:0] mt;
        logic [2:0] ms;
        logic [2:0] mp;

        // Inputs are applied before edge k; outputs expected after it.
        tbl[0]  = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 1'b0, 3'b000};
        tbl[1]  = '{3'b111, 1'b0, 1'b1, 2'd3, 8'd9, 3'b000, 3'b000, 1'b1, 3'b000};
        tbl[2]  = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 1'b0, 3'b000};
        tbl[3]  = '{3'b111, 1'b0, 1'b1, 2'd2, 8'd0, 3'b111, 3'b111, 1'b0, 3'b000};
        tbl[4]  = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b100, 3'b011, 1'b0, 3'b000};
        tbl[5]  = '{3'b111, 1'b0, 1'b1, 2'd0, 8'd1, 3'b100, 3'b111, 1'b0, 3'b001};
        tbl[6]  = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b100, 3'b011, 1'b0, 3'b001};
        tbl[7]  = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b111, 3'b100, 1'b0, 3'b000};
        tbl[8]  = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b100, 3'b000, 1'b0, 3'b000};
        tbl[9]  = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b101, 3'b101, 1'b0, 3'b000};
        tbl[10] = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b100, 3'b001, 1'b0, 3'b000};
        tbl[11] = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b111, 3'b110, 1'b0, 3'b000};
        tbl[12] = '{3'b111, 1'b1, 1'b1, 2'd1, 8'd1, 3'b000, 3'b000, 1'b0, 3'b000};
        tbl[13] = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b100, 3'b100, 1'b0, 3'b000};
        tbl[14] = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b111, 3'b011, 1'b0, 3'b000};
        tbl[15] = '{3'b110, 1'b0, 1'b0, 2'd0, 8'd0, 3'b100, 3'b110, 1'b0, 3'b000};
        tbl[16] = '{3'b110, 1'b0, 1'b0, 2'd0, 8'd0, 3'b110, 3'b000, 1'b0, 3'b000};
        tbl[17] = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b100, 3'b100, 1'b0, 3'b000};
        tbl[18] = '{3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 3'b111, 3'b011, 1'b0, 3'b000};

        // Reset state
        drive(3'b000, 1'b0, 1'b0, 2'd0, 8'd0);
        rst = 1'b1;
        step();
        step();
        chk("rst_tick", 0, 32'(bus.o_tick), 32'd0);
        chk("rst_slow", 0, 32'(bus.o_slow_clk), 32'd0);
        chk("rst_err", 0, 32'(bus.o_wr_err), 32'd0);
        rst = 1'b0;

        // Directed vector table
        for (int k = 0; k < 19; k++) begin
            drive(tbl[k].en, tbl[k].sy, tbl[k].wr, tbl[k].ch, tbl[k].dv);
            step();
            chk("vec_tick", k, 32'(bus.o_tick), 32'(tbl[k].tick));
            chk("vec_slow", k, 32'(bus.o_slow_clk), 32'(tbl[k].slow));
            chk("vec_err", k, 32'(bus.o_wr_err), 32'(tbl[k].err));
`ifdef CLKDIV_PENDING_EN
            chk("vec_pend", k, 32'(bus.o_pending), 32'(tbl[k].pend));
`endif
        end

        // Reset mid-run: everything clears and the default divide returns
        drive(3'b111, 1'b0, 1'b1, 2'd0, 8'd5);
        rst = 1'b1;
        step();
        chk("mid_rst_tick", 0, 32'(bus.o_tick), 32'd0);
        chk("mid_rst_slow", 0, 32'(bus.o_slow_clk), 32'd0);
        chk("mid_rst_err", 0, 32'(bus.o_wr_err), 32'd0);
        rst = 1'b0;
        drive(3'b111, 1'b0, 1'b0, 2'd0, 8'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("post_rst_tick", k, 32'(bus.o_tick), (k == 4) ? 32'h7 : 32'h0);
            chk("post_rst_slow", k, 32'(bus.o_slow_clk), (k == 4) ? 32'h7 : 32'h0);
        end

        // Randomized stimulus against the model
        for (int n = 0; n < 600; n++) begin
            logic [2:0] en;
            en[0] = ($urandom_range(0, 9) != 0);
            en[1] = ($urandom_range(0, 9) != 0);
            en[2] = ($urandom_range(0, 9) != 0);
            drive(en, ($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                  2'($urandom_range(0, 3)), 8'($urandom_range(0, 5)));
            rst = ($urandom_range(0, 149) == 0);
            step();
            for (int c = 0; c < NCH; c++) begin
                mt[c] = m_tick[c];
                ms[c] = m_slow[c];
                mp[c] = m_pend[c];
            end
            chk("rnd_tick", n, 32'(bus.o_tick), 32'(mt));
            chk("rnd_slow", n, 32'(bus.o_slow_clk), 32'(ms));
            chk("rnd_err", n, 32'(bus.o_wr_err), 32'(m_err));
`ifdef CLKDIV_PENDING_EN
            chk("rnd_pend", n, 32'(bus.o_pending), 32'(mp));
`else
            if (mp === 3'bxxx) chk("rnd_pend_x", n, 32'(mp), 32'd0);
`endif
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
